// File: rtl/mole_scheduler_pkg.sv
// mole_scheduler_pkg
// Shared definitions for the mole spawn/expiry engine:
//   NUM_HOLES      - number of holes on the board (default for HOLE_NUM)
//   LFSR_TAPS      - Galois feedback mask for x^16+x^14+x^13+x^11+1
//   sched_state_e  - scheduler states SCHED_IDLE/WAIT/PROBE/PLACE
//   fold_hole()    - folds a 5-bit random value into 0..NUM_HOLES-1
//   next_hole()    - advances a hole index with wrap to 0
package mole_scheduler_pkg;

  localparam int NUM_HOLES = 20;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_WAIT  = 2'd1,
    SCHED_PROBE = 2'd2,
    SCHED_PLACE = 2'd3
  } sched_state_e;

  // A single conditional subtract is enough because the input never exceeds 31.
  function automatic logic [4:0] fold_hole(input logic [4:0] raw);
    fold_hole = (raw >= 5'(NUM_HOLES)) ? raw - 5'(NUM_HOLES) : raw;
  endfunction

  function automatic logic [4:0] next_hole(input logic [4:0] h);
    next_hole = (h == 5'(NUM_HOLES - 1)) ? 5'd0 : h + 5'd1;
  endfunction

endpackage

// File: rtl/mole_scheduler_lfsr.sv
// mole_lfsr
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) that steps once per cycle
// while enabled and holds otherwise.
// Ports:
//   clk    in  - system clock
//   rst_n  in  - asynchronous active-low reset, loads SEED
//   en     in  - advance enable
//   state  out - current 16-bit LFSR state
module mole_lfsr
  import mole_scheduler_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Right-shifting Galois form: the bit shifted out feeds back through the tap mask.
  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler
// Spawn-and-expiry engine for the whack-a-mole board. Owns mole occupancy and
// per-hole lifetimes, spawns a mole into a pseudo-random free hole every
// gen_interval cycles, and retires moles on hit or timeout.
// Optional feature macro: MOLE_SCHED_CAP_EN (active-mole cap of MAX_ACTIVE).
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   game_en           - high while playing; low clears the board next edge
//   life_span         - mole lifetime in cycles (0 behaves as 1)
//   gen_interval      - cycles between spawn attempts (0 behaves as 1)
//   hit_valid/hit_hole- single-cycle touch strobe and hole index
//   moles             - occupancy vector, bit i = hole i has a mole
//   spawn_pulse/hole  - a mole was placed, and where (hole index holds)
//   kill_pulse        - a hit removed a mole
//   miss_pulse        - a hit landed on an empty hole
//   escape_pulse      - one or more moles timed out
//   active_cnt        - number of moles currently on the board
module mole_scheduler
  import mole_scheduler_pkg::*;
#(
  parameter int          HOLE_NUM   = NUM_HOLES,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          MAX_ACTIVE = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                game_en,
  input  logic [31:0]         life_span,
  input  logic [31:0]         gen_interval,
  input  logic                hit_valid,
  input  logic [4:0]          hit_hole,
  output logic [HOLE_NUM-1:0] moles,
  output logic                spawn_pulse,
  output logic [4:0]          spawn_hole,
  output logic                kill_pulse,
  output logic                miss_pulse,
  output logic                escape_pulse,
  output logic [4:0]          active_cnt
);

`ifdef MOLE_SCHED_CAP_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  sched_state_e        state_q, state_d;
  logic [31:0]         interval_q, interval_d;
  logic [4:0]          cand_q, cand_d;
  logic [4:0]          probe_cnt_q, probe_cnt_d;
  logic [31:0]         life_q [HOLE_NUM];
  logic [31:0]         life_d [HOLE_NUM];
  logic [HOLE_NUM-1:0] moles_q, moles_d;
  logic                spawn_pulse_q, spawn_pulse_d;
  logic [4:0]          spawn_hole_q, spawn_hole_d;
  logic                kill_q, kill_d;
  logic                miss_q, miss_d;
  logic                escape_q, escape_d;
  logic [4:0]          active_cnt_q, active_cnt_d;

  logic [31:0]         life_eff;
  logic [31:0]         interval_eff;
  logic                hit_ok;
  logic                cap_hit;
  logic [15:0]         lfsr_state;
  logic                unused_lfsr_bits;

  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (game_en),
    .state (lfsr_state)
  );

  // Only the low five bits pick a hole; the rest only matter for the sequence.
  assign unused_lfsr_bits = ^lfsr_state[15:5];

  // Next-state logic. Lifetime and hit handling run first so that a hit on a
  // hole whose counter is at 1 is reported as a kill only. Placement runs
  // last and wins on its own hole, which can only be empty at that point, so
  // a same-cycle hit there has already been reported as a miss.
  always_comb begin
    life_eff     = (life_span == 32'd0) ? 32'd1 : life_span;
    interval_eff = (gen_interval == 32'd0) ? 32'd1 : gen_interval;
    hit_ok       = hit_valid && (hit_hole < 5'(HOLE_NUM));
    cap_hit      = CAP_EN && (32'(active_cnt_q) >= 32'(MAX_ACTIVE));

    state_d       = state_q;
    interval_d    = interval_q;
    cand_d        = cand_q;
    probe_cnt_d   = probe_cnt_q;
    moles_d       = moles_q;
    life_d        = life_q;
    spawn_hole_d  = spawn_hole_q;
    spawn_pulse_d = 1'b0;
    kill_d        = 1'b0;
    miss_d        = 1'b0;
    escape_d      = 1'b0;

    if (!game_en) begin
      moles_d = '0;
      for (int i = 0; i < HOLE_NUM; i++) begin
        life_d[i] = '0;
      end
      state_d = SCHED_IDLE;
    end else begin
      for (int i = 0; i < HOLE_NUM; i++) begin
        if (moles_q[i]) begin
          if (hit_ok && (hit_hole == 5'(i))) begin
            moles_d[i] = 1'b0;
            life_d[i]  = '0;
            kill_d     = 1'b1;
          end else if (life_q[i] == 32'd1) begin
            moles_d[i] = 1'b0;
            life_d[i]  = '0;
            escape_d   = 1'b1;
          end else begin
            life_d[i] = life_q[i] - 32'd1;
          end
        end
      end

      if (hit_ok && !moles_q[hit_hole]) begin
        miss_d = 1'b1;
      end

      case (state_q)
        SCHED_IDLE: begin
          state_d    = SCHED_WAIT;
          interval_d = interval_eff;
        end
        SCHED_WAIT: begin
          if (interval_q == 32'd1) begin
            if (cap_hit) begin
              interval_d = interval_eff;
            end else begin
              state_d     = SCHED_PROBE;
              cand_d      = fold_hole(lfsr_state[4:0]);
              probe_cnt_d = '0;
            end
          end else begin
            interval_d = interval_q - 32'd1;
          end
        end
        SCHED_PROBE: begin
          if (!moles_q[cand_q]) begin
            state_d = SCHED_PLACE;
          end else begin
            cand_d = next_hole(cand_q);
            // The last of HOLE_NUM occupied probes means the board is full.
            if (probe_cnt_q == 5'(HOLE_NUM - 1)) begin
              state_d    = SCHED_WAIT;
              interval_d = interval_eff;
            end else begin
              probe_cnt_d = probe_cnt_q + 5'd1;
            end
          end
        end
        SCHED_PLACE: begin
          if (moles_q[cand_q]) begin
            state_d = SCHED_PROBE;
          end else begin
            moles_d[cand_q] = 1'b1;
            life_d[cand_q]  = life_eff;
            spawn_pulse_d   = 1'b1;
            spawn_hole_d    = cand_q;
            state_d         = SCHED_WAIT;
            interval_d      = interval_eff;
          end
        end
        default: state_d = SCHED_IDLE;
      endcase
    end

    // Registered alongside moles so the count always matches the visible board.
    active_cnt_d = '0;
    for (int i = 0; i < HOLE_NUM; i++) begin
      active_cnt_d = active_cnt_d + {4'd0, moles_d[i]};
    end
  end

  // All scheduler state and every output are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SCHED_IDLE;
      interval_q    <= '0;
      cand_q        <= '0;
      probe_cnt_q   <= '0;
      moles_q       <= '0;
      for (int i = 0; i < HOLE_NUM; i++) begin
        life_q[i] <= '0;
      end
      spawn_pulse_q <= 1'b0;
      spawn_hole_q  <= '0;
      kill_q        <= 1'b0;
      miss_q        <= 1'b0;
      escape_q      <= 1'b0;
      active_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      interval_q    <= interval_d;
      cand_q        <= cand_d;
      probe_cnt_q   <= probe_cnt_d;
      moles_q       <= moles_d;
      life_q        <= life_d;
      spawn_pulse_q <= spawn_pulse_d;
      spawn_hole_q  <= spawn_hole_d;
      kill_q        <= kill_d;
      miss_q        <= miss_d;
      escape_q      <= escape_d;
      active_cnt_q  <= active_cnt_d;
    end
  end

  assign moles        = moles_q;
  assign spawn_pulse  = spawn_pulse_q;
  assign spawn_hole   = spawn_hole_q;
  assign kill_pulse   = kill_q;
  assign miss_pulse   = miss_q;
  assign escape_pulse = escape_q;
  assign active_cnt   = active_cnt_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler
// Drives mole_scheduler at the falling edge, predicts each cycle's outputs
// with a behavioural board model, queues the prediction, and an independent
// monitor compares the queued prediction with the DUT after each rising edge.
module tb_mole_scheduler;

  localparam int HOLES = 20;
  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_PROBE = 2;
  localparam int P_PLACE = 3;
`ifdef MOLE_SCHED_CAP_EN
  localparam int FULL_TARGET = 6;
`else
  localparam int FULL_TARGET = 20;
`endif

  typedef struct packed {
    logic [19:0] moles;
    logic        sp;
    logic [4:0]  sh;
    logic        kill;
    logic        miss;
    logic        esc;
    logic [4:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        game_en = 1'b0;
  logic [31:0] life_span = 32'd1;
  logic [31:0] gen_interval = 32'd1;
  logic        hit_valid = 1'b0;
  logic [4:0]  hit_hole = 5'd0;
  logic [19:0] moles;
  logic        spawn_pulse;
  logic [4:0]  spawn_hole;
  logic        kill_pulse;
  logic        miss_pulse;
  logic        escape_pulse;
  logic [4:0]  active_cnt;

  always #5 clk = ~clk;

  mole_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .game_en      (game_en),
    .life_span    (life_span),
    .gen_interval (gen_interval),
    .hit_valid    (hit_valid),
    .hit_hole     (hit_hole),
    .moles        (moles),
    .spawn_pulse  (spawn_pulse),
    .spawn_hole   (spawn_hole),
    .kill_pulse   (kill_pulse),
    .miss_pulse   (miss_pulse),
    .escape_pulse (escape_pulse),
    .active_cnt   (active_cnt)
  );

  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;
  exp_t last_exp;
  logic [31:0] cfg_life = 32'd5;
  logic [31:0] cfg_gi = 32'd10;

  // Board model: remaining visible cycles per hole (0 = empty), the random
  // source, and where the spawner is in its attempt cycle.
  longint unsigned m_life[HOLES];
  logic [15:0]     m_lfsr;
  int              m_phase;
  longint unsigned m_wait;
  int              m_cand;
  int              m_probes;
  logic [4:0]      m_spawn_hole;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < HOLES; i++) if (m_life[i] != 0) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < HOLES; i++) m_life[i] = 0;
    m_lfsr = 16'hACE1;
    m_phase = P_IDLE;
    m_wait = 0;
    m_cand = 0;
    m_probes = 0;
    m_spawn_hole = 5'd0;
  endtask

  // Advance the model across one rising edge and return what the DUT must show after it.
  task automatic model_step(input bit rstn, input bit ge, input bit hv, input logic [4:0] hh,
                            input logic [31:0] ls, input logic [31:0] gi, output exp_t e);
    longint unsigned nl[HOLES];
    longint unsigned life_eff;
    longint unsigned gi_eff;
    bit kill = 0, miss = 0, esc = 0, sp = 0, hv_ok;
    life_eff = (ls == 0) ? 1 : longint'(ls);
    gi_eff = (gi == 0) ? 1 : longint'(gi);
    if (!rstn) begin
      model_reset();
    end else if (!ge) begin
      for (int i = 0; i < HOLES; i++) m_life[i] = 0;
      m_phase = P_IDLE;
    end else begin
      hv_ok = hv && (int'(hh) < HOLES);
      nl = m_life;
      for (int i = 0; i < HOLES; i++) begin
        if (m_life[i] != 0) begin
          if (hv_ok && int'(hh) == i) begin nl[i] = 0; kill = 1; end
          else if (m_life[i] == 1) begin nl[i] = 0; esc = 1; end
          else nl[i] = m_life[i] - 1;
        end
      end
      if (hv_ok && m_life[hh] == 0) miss = 1;
      case (m_phase)
        P_IDLE: begin m_phase = P_WAIT; m_wait = gi_eff; end
        P_WAIT: begin
          if (m_wait == 1) begin
`ifdef MOLE_SCHED_CAP_EN
            if (model_count() >= 6) m_wait = gi_eff;
            else begin m_phase = P_PROBE; m_cand = int'(m_lfsr[4:0]) % HOLES; m_probes = 0; end
`else
            m_phase = P_PROBE; m_cand = int'(m_lfsr[4:0]) % HOLES; m_probes = 0;
`endif
          end else m_wait = m_wait - 1;
        end
        P_PROBE: begin
          if (m_life[m_cand] == 0) m_phase = P_PLACE;
          else begin
            m_cand = (m_cand + 1) % HOLES;
            m_probes++;
            if (m_probes == HOLES) begin m_phase = P_WAIT; m_wait = gi_eff; end
          end
        end
        default: begin
          if (m_life[m_cand] != 0) m_phase = P_PROBE;
          else begin
            nl[m_cand] = life_eff;
            sp = 1;
            m_spawn_hole = 5'(m_cand);
            m_phase = P_WAIT;
            m_wait = gi_eff;
          end
        end
      endcase
      m_life = nl;
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
    e = '0;
    for (int i = 0; i < HOLES; i++) e.moles[i] = (m_life[i] != 0);
    e.cnt = 5'(model_count());
    e.sh = m_spawn_hole;
    e.sp = sp;
    e.kill = kill;
    e.miss = miss;
    e.esc = esc;
  endtask

  // One cycle of stimulus: drive at the falling edge and queue the prediction.
  task automatic applyStimulus(input bit rstn, input bit ge, input bit hv, input logic [4:0] hh);
    exp_t e;
    @(negedge clk);
    game_en = ge;
    hit_valid = hv;
    hit_hole = hh;
    life_span = cfg_life;
    gen_interval = cfg_gi;
    if (!rstn && rst_n) begin
      rst_n = 1'b0;
      #1;
      checkOutput("reset_moles", 32'(moles), 32'd0);
      checkOutput("reset_spawn", {31'd0, spawn_pulse}, 32'd0);
      checkOutput("reset_spawn_hole", 32'(spawn_hole), 32'd0);
      checkOutput("reset_pulses", {29'd0, kill_pulse, miss_pulse, escape_pulse}, 32'd0);
      checkOutput("reset_active_cnt", 32'(active_cnt), 32'd0);
    end
    rst_n = rstn;
    model_step(rstn, ge, hv, hh, cfg_life, cfg_gi, e);
    last_exp = e;
    mon_en = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising edge pops one prediction and compares it with the DUT.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checkOutput("queue_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("moles", 32'(moles), 32'(mon_e.moles));
        checkOutput("spawn_pulse", {31'd0, spawn_pulse}, {31'd0, mon_e.sp});
        checkOutput("spawn_hole", 32'(spawn_hole), 32'(mon_e.sh));
        checkOutput("kill_pulse", {31'd0, kill_pulse}, {31'd0, mon_e.kill});
        checkOutput("miss_pulse", {31'd0, miss_pulse}, {31'd0, mon_e.miss});
        checkOutput("escape_pulse", {31'd0, escape_pulse}, {31'd0, mon_e.esc});
        checkOutput("active_cnt", 32'(active_cnt), 32'(mon_e.cnt));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first_sp, first_esc, found, h, empty_h, spawns, r;
    int occ[$];
    logic [4:0] hh;
    bit ge, hv, rstn;

    model_reset();

    // Reset held for a few cycles, then released with the game off.
    cfg_life = 32'd5;
    cfg_gi = 32'd10;
    repeat (3) applyStimulus(0, 0, 0, 5'd0);
    applyStimulus(1, 0, 0, 5'd0);

    // Single spawn and expiry: WAIT is entered at n=0; the mole shows up after
    // gen_interval WAIT cycles plus one PROBE and one PLACE cycle.
    first_sp = -1;
    first_esc = -1;
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1, 1, 0, 5'd0);
      @(posedge clk);
      #2;
      if (spawn_pulse && first_sp < 0) first_sp = n;
      if (escape_pulse && first_esc < 0) first_esc = n;
    end
    checkOutput("first_spawn_latency", 32'(first_sp), cfg_gi + 32'd2);
    checkOutput("visible_cycles", 32'(first_esc - first_sp), cfg_life);
    applyStimulus(1, 0, 0, 5'd0);

    // Kill, miss and out-of-range hit.
    cfg_gi = 32'd4;
    cfg_life = 32'd30;
    found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      applyStimulus(1, 1, 0, 5'd0);
      if (last_exp.sp) found = 1;
    end
    checkOutput("kill_setup_spawned", 32'(found), 32'd1);
    h = int'(last_exp.sh);
    applyStimulus(1, 1, 0, 5'd0);
    applyStimulus(1, 1, 0, 5'd0);
    applyStimulus(1, 1, 1, 5'(h));
    @(posedge clk);
    #2;
    checkOutput("directed_kill", {31'd0, kill_pulse}, 32'd1);
    checkOutput("directed_kill_clear", {31'd0, moles[h]}, 32'd0);
    checkOutput("directed_kill_no_escape", {31'd0, escape_pulse}, 32'd0);
    empty_h = 0;
    for (int i = HOLES - 1; i >= 0; i--) if (m_life[i] == 0) empty_h = i;
    applyStimulus(1, 1, 1, 5'(empty_h));
    @(posedge clk);
    #2;
    checkOutput("directed_miss", {31'd0, miss_pulse}, 32'd1);
    applyStimulus(1, 1, 1, 5'd25);
    @(posedge clk);
    #2;
    checkOutput("hit_out_of_range", {30'd0, kill_pulse, miss_pulse}, 32'd0);

    // Hit on a mole in its last visible cycle counts only as a kill.
    applyStimulus(1, 0, 0, 5'd0);
    cfg_life = 32'd3;
    cfg_gi = 32'd2;
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      h = -1;
      for (int i = 0; i < HOLES; i++) if (m_life[i] == 1) h = i;
      if (h >= 0) begin
        applyStimulus(1, 1, 1, 5'(h));
        @(posedge clk);
        #2;
        checkOutput("collision_kill", {31'd0, kill_pulse}, 32'd1);
        checkOutput("collision_no_escape", {31'd0, escape_pulse}, 32'd0);
        found = 1;
      end else begin
        applyStimulus(1, 1, 0, 5'd0);
      end
    end
    checkOutput("collision_reached", 32'(found), 32'd1);

    // Fill the board with immortal moles, then watch attempts fail.
    applyStimulus(1, 0, 0, 5'd0);
    cfg_life = 32'hFFFF_FFFF;
    cfg_gi = 32'd1;
    for (int n = 0; n < 2000 && model_count() < FULL_TARGET; n++) applyStimulus(1, 1, 0, 5'd0);
    @(posedge clk);
    #2;
`ifndef MOLE_SCHED_CAP_EN
    checkOutput("full_board_moles", 32'(moles), 32'h000F_FFFF);
`endif
    checkOutput("full_board_active_cnt", 32'(active_cnt), 32'(FULL_TARGET));
    spawns = 0;
    for (int n = 0; n < 100; n++) begin
      applyStimulus(1, 1, 0, 5'd0);
      @(posedge clk);
      #2;
      if (spawn_pulse) spawns++;
    end
    checkOutput("full_board_no_spawn", 32'(spawns), 32'd0);

    // Drop game_en while the scheduler is probing.
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (m_phase == P_PROBE) found = 1;
      else applyStimulus(1, 1, 0, 5'd0);
    end
    checkOutput("probe_reached", 32'(found), 32'd1);
    applyStimulus(1, 0, 0, 5'd0);
    @(posedge clk);
    #2;
    checkOutput("disable_clears_moles", 32'(moles), 32'd0);

    // Reset in the middle of a long WAIT; the following spawns must follow the reseeded LFSR.
    cfg_gi = 32'd50;
    cfg_life = 32'd10;
    repeat (10) applyStimulus(1, 1, 0, 5'd0);
    applyStimulus(0, 1, 0, 5'd0);
    applyStimulus(0, 1, 0, 5'd0);
    cfg_gi = 32'd3;
    cfg_life = 32'd8;
    repeat (60) applyStimulus(1, 1, 0, 5'd0);

    // Randomized play.
    for (int n = 0; n < 1500; n++) begin
      if (n % 50 == 0) begin
        cfg_life = 32'($urandom_range(0, 40));
        cfg_gi = 32'($urandom_range(0, 8));
      end
      rstn = ($urandom_range(0, 499) != 0);
      ge = ($urandom_range(0, 99) != 0);
      r = int'($urandom_range(0, 9));
      hv = 1'b0;
      hh = 5'd0;
      if (r < 3) begin
        occ.delete();
        for (int i = 0; i < HOLES; i++) if (m_life[i] != 0) occ.push_back(i);
        hv = 1'b1;
        if (occ.size() > 0) hh = 5'(occ[$urandom_range(0, occ.size() - 1)]);
        else hh = 5'($urandom_range(0, 19));
      end else if (r < 5) begin
        hv = 1'b1;
        hh = 5'($urandom_range(0, 31));
      end
      applyStimulus(rstn, ge, hv, hh);
    end

    applyStimulus(1, 0, 0, 5'd0);
    @(posedge clk);
    #3;
    checkOutput("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
